// File: rtl/collision_scheduler_pkg.sv
// Shared constants and encodings for the light-bike collision scheduler.
package collision_scheduler_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned PIX_TOTAL = 307200;
  localparam int unsigned ADDR_W    = 19;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ORIENT_UP    = 2'd0,
    ORIENT_LEFT  = 2'd1,
    ORIENT_DOWN  = 2'd2,
    ORIENT_RIGHT = 2'd3
  } orient_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRACE = 2'd1,
    ST_ARMED = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/collision_scheduler_probe_addr_gen.sv
// Two look-ahead probe addresses 16 px in front of a bike, 5 px either side of its centre line.
module probe_addr_gen
  import collision_scheduler_pkg::*;
#(
  parameter int unsigned SCREEN_W  = collision_scheduler_pkg::SCREEN_W,
  parameter int unsigned PIX_TOTAL = collision_scheduler_pkg::PIX_TOTAL
) (
  input  addr_t   mid,
  input  orient_t orient,
  output addr_t   probe_a,
  output addr_t   probe_b,
  output logic    valid_a,
  output logic    valid_b
);

  localparam addr_t OFF5  = addr_t'(5);
  localparam addr_t OFF16 = addr_t'(16);
  localparam addr_t ROW5  = addr_t'(5 * SCREEN_W);
  localparam addr_t ROW16 = addr_t'(16 * SCREEN_W);

  // Arithmetic wraps mod 2^19; wrapped results land above PIX_TOTAL and are masked off.
  always_comb begin
    probe_a = mid;
    probe_b = mid;
    case (orient)
      ORIENT_UP:    begin probe_a = mid - OFF5 - ROW16;  probe_b = mid + OFF5 - ROW16;  end
      ORIENT_LEFT:  begin probe_a = mid - OFF16 - ROW5;  probe_b = mid - OFF16 + ROW5;  end
      ORIENT_DOWN:  begin probe_a = mid + OFF5 + ROW16;  probe_b = mid - OFF5 + ROW16;  end
      ORIENT_RIGHT: begin probe_a = mid + OFF16 - ROW5;  probe_b = mid + OFF16 + ROW5;  end
      default:      begin probe_a = mid;                 probe_b = mid;                 end
    endcase
  end

  assign valid_a = (32'(probe_a) < PIX_TOTAL);
  assign valid_b = (32'(probe_b) < PIX_TOTAL);

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision scheduler: probes the VGA scan ahead of each bike, debounces hits
// over consecutive frames and reports crash/draw/game-over to the game FSM.
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int unsigned SCREEN_W     = collision_scheduler_pkg::SCREEN_W,
  parameter int unsigned PIX_TOTAL    = collision_scheduler_pkg::PIX_TOTAL,
  parameter int unsigned HIT_FRAMES   = 2,
  parameter int unsigned GRACE_FRAMES = 30
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        game_start,
  input  logic        frame_end,
  input  logic [18:0] addr,
  input  logic [7:0]  pixel_color,
  input  logic [7:0]  road_color,
  input  logic [18:0] bike0_mid,
  input  logic [1:0]  bike0_orient,
  input  logic [18:0] bike1_mid,
  input  logic [1:0]  bike1_orient,
  input  logic        crash_ack,
  output logic [1:0]  crash,
  output logic        draw,
  output logic        game_over,
  output logic [1:0]  state_dbg
);

  localparam int unsigned SW = $clog2(HIT_FRAMES + 1);
  localparam int unsigned GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam logic [SW-1:0] HIT_MAX    = SW'(HIT_FRAMES);
  localparam logic [GW-1:0] GRACE_INIT = GW'(GRACE_FRAMES);

  state_t          state, state_nx;
  addr_t           mid_q    [2];
  orient_t         orient_q [2];
  addr_t           probe_a  [2];
  addr_t           probe_b  [2];
  logic [1:0]      valid_a, valid_b;
  logic [1:0]      hit_flag, hit_now, frame_hit, crash_nx;
  logic [SW-1:0]   streak_q [2];
  logic [SW-1:0]   streak_nx[2];
  logic [GW-1:0]   grace_cnt;
  logic            active;

  probe_addr_gen #(.SCREEN_W(SCREEN_W), .PIX_TOTAL(PIX_TOTAL)) u_probe0 (
    .mid(mid_q[0]), .orient(orient_q[0]),
    .probe_a(probe_a[0]), .probe_b(probe_b[0]),
    .valid_a(valid_a[0]), .valid_b(valid_b[0])
  );

  probe_addr_gen #(.SCREEN_W(SCREEN_W), .PIX_TOTAL(PIX_TOTAL)) u_probe1 (
    .mid(mid_q[1]), .orient(orient_q[1]),
    .probe_a(probe_a[1]), .probe_b(probe_b[1]),
    .valid_a(valid_a[1]), .valid_b(valid_b[1])
  );

  // frame_hit folds in the current cycle so a hit on the frame_end cycle counts for that frame.
  always_comb begin
    active = (state == ST_GRACE) || (state == ST_ARMED);
    for (int unsigned b = 0; b < 2; b++) begin
      hit_now[b]   = active && (pixel_color != road_color) &&
                     ((valid_a[b] && (addr == probe_a[b])) || (valid_b[b] && (addr == probe_b[b])));
      frame_hit[b] = hit_flag[b] | hit_now[b];
      if (!frame_hit[b])               streak_nx[b] = '0;
      else if (streak_q[b] == HIT_MAX) streak_nx[b] = HIT_MAX;
      else                             streak_nx[b] = streak_q[b] + SW'(1);
      crash_nx[b] = (streak_nx[b] == HIT_MAX);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (game_start) state_nx = (GRACE_FRAMES == 0) ? ST_ARMED : ST_GRACE;
      ST_GRACE: if (frame_end && (grace_cnt <= GW'(1))) state_nx = ST_ARMED;
      ST_ARMED: if (frame_end && (|crash_nx)) state_nx = ST_OVER;
      ST_OVER:  if (crash_ack) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      crash     <= '0;
      draw      <= 1'b0;
      game_over <= 1'b0;
      hit_flag  <= '0;
      grace_cnt <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        mid_q[b]    <= '0;
        orient_q[b] <= ORIENT_UP;
        streak_q[b] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: if (game_start) begin
          grace_cnt <= GRACE_INIT;
          hit_flag  <= '0;
          mid_q[0]  <= bike0_mid;  orient_q[0] <= orient_t'(bike0_orient);
          mid_q[1]  <= bike1_mid;  orient_q[1] <= orient_t'(bike1_orient);
          for (int unsigned b = 0; b < 2; b++) streak_q[b] <= '0;
        end
        ST_GRACE, ST_ARMED: begin
          if (frame_end) begin
            hit_flag <= '0;
            mid_q[0] <= bike0_mid;  orient_q[0] <= orient_t'(bike0_orient);
            mid_q[1] <= bike1_mid;  orient_q[1] <= orient_t'(bike1_orient);
            if (state == ST_GRACE) begin
              grace_cnt <= grace_cnt - GW'(1);
              for (int unsigned b = 0; b < 2; b++) streak_q[b] <= '0;
            end else begin
              for (int unsigned b = 0; b < 2; b++) streak_q[b] <= streak_nx[b];
              if (|crash_nx) begin
                crash     <= crash_nx;
                draw      <= &crash_nx;
                game_over <= 1'b1;
              end
            end
          end else begin
            hit_flag <= frame_hit;
          end
        end
        ST_OVER: if (crash_ack) begin
          crash     <= '0;
          draw      <= 1'b0;
          game_over <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: one instance with no grace period, one with three grace frames.
module tb_collision_scheduler;

  localparam logic [7:0] ROAD = 8'h00;
  localparam logic [7:0] WALL = 8'h1C;

  logic        clock = 1'b0;
  logic        resetn, game_start, frame_end, crash_ack;
  logic [18:0] addr, bike0_mid, bike1_mid;
  logic [7:0]  pixel_color, road_color;
  logic [1:0]  bike0_orient, bike1_orient;

  logic [1:0]  crash_a, crash_g, state_a, state_g;
  logic        draw_a, draw_g, over_a, over_g;

  logic [18:0] target0, target1;

  typedef struct {
    string       tag;
    int unsigned which;
    logic [5:0]  exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clock = ~clock;

  collision_scheduler #(.HIT_FRAMES(2), .GRACE_FRAMES(0)) dut_a (
    .clock(clock), .resetn(resetn), .game_start(game_start), .frame_end(frame_end),
    .addr(addr), .pixel_color(pixel_color), .road_color(road_color),
    .bike0_mid(bike0_mid), .bike0_orient(bike0_orient),
    .bike1_mid(bike1_mid), .bike1_orient(bike1_orient),
    .crash_ack(crash_ack), .crash(crash_a), .draw(draw_a), .game_over(over_a),
    .state_dbg(state_a)
  );

  collision_scheduler #(.HIT_FRAMES(2), .GRACE_FRAMES(3)) dut_g (
    .clock(clock), .resetn(resetn), .game_start(game_start), .frame_end(frame_end),
    .addr(addr), .pixel_color(pixel_color), .road_color(road_color),
    .bike0_mid(bike0_mid), .bike0_orient(bike0_orient),
    .bike1_mid(bike1_mid), .bike1_orient(bike1_orient),
    .crash_ack(crash_ack), .crash(crash_g), .draw(draw_g), .game_over(over_g),
    .state_dbg(state_g)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {state,over,draw,crash}=%b expected %b", tag, got[5:0], exp[5:0]);
    end
  endtask

  function automatic logic [5:0] observe(input int unsigned which);
    return (which == 0) ? {state_a, over_a, draw_a, crash_a} : {state_g, over_g, draw_g, crash_g};
  endfunction

  task automatic expect_out(input string tag, input int unsigned which, input logic [1:0] st,
                            input logic ov, input logic dr, input logic [1:0] cr);
    exp_t e;
    e.tag = tag; e.which = which; e.exp = {st, ov, dr, cr};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, 32'(observe(e.which)), 32'(e.exp));
    end
  endtask

  task automatic cycle();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    game_start = 1'b0; frame_end = 1'b0; crash_ack = 1'b0;
    addr = '0; pixel_color = ROAD;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
  endtask

  task automatic pulse_start();
    game_start = 1'b1;
    cycle();
    game_start = 1'b0;
  endtask

  task automatic pulse_ack();
    crash_ack = 1'b1;
    cycle();
    crash_ack = 1'b0;
  endtask

  // Two scan cycles over the target addresses, then the frame_end cycle (optionally carrying a bike-0 hit).
  task automatic run_frame(input bit h0, input bit h1, input bit h0_on_end);
    addr = target0; pixel_color = h0 ? WALL : ROAD;
    cycle();
    addr = target1; pixel_color = h1 ? WALL : ROAD;
    cycle();
    addr = h0_on_end ? target0 : 19'd0;
    pixel_color = h0_on_end ? WALL : ROAD;
    frame_end = 1'b1;
    cycle();
    idle_inputs();
  endtask

  task automatic frame_chk(input string tag, input int unsigned which, input bit h0, input bit h1,
                           input bit he, input logic [1:0] st, input logic ov, input logic dr,
                           input logic [1:0] cr);
    expect_out(tag, which, st, ov, dr, cr);
    run_frame(h0, h1, he);
    drain();
  endtask

  initial begin
    idle_inputs();
    road_color   = ROAD;
    bike0_mid    = 19'd100000; bike0_orient = 2'd0;  // up: probe 89765 = 100000+5-16*640
    bike1_mid    = 19'd200000; bike1_orient = 2'd3;  // right: probe 196816 = 200000+16-5*640
    target0      = 19'd89765;
    target1      = 19'd196816;
    resetn       = 1'b0;
    cycle(); cycle();
    resetn = 1'b1;
    expect_out("reset_a", 0, 2'd0, 1'b0, 1'b0, 2'b00);
    expect_out("reset_g", 1, 2'd0, 1'b0, 1'b0, 2'b00);
    drain();

    // Reset while armed with a streak and a pending hit flag
    pulse_start();
    expect_out("start_a", 0, 2'd2, 1'b0, 1'b0, 2'b00);
    expect_out("start_g", 1, 2'd1, 1'b0, 1'b0, 2'b00);
    drain();
    frame_chk("t1_f1", 0, 1, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    addr = target0; pixel_color = WALL;
    cycle();
    expect_out("t1_rst_a", 0, 2'd0, 1'b0, 1'b0, 2'b00);
    expect_out("t1_rst_g", 1, 2'd0, 1'b0, 1'b0, 2'b00);
    do_reset();
    drain();

    // Two consecutive hit frames on bike 0
    pulse_start();
    frame_chk("t2_f1", 0, 1, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    frame_chk("t2_f2", 0, 1, 0, 0, 2'd3, 1'b1, 1'b0, 2'b01);
    expect_out("t6_start_in_over", 0, 2'd3, 1'b1, 1'b0, 2'b01);
    pulse_start();
    addr = target0; pixel_color = WALL;
    cycle();
    idle_inputs();
    drain();
    expect_out("t2_ack", 0, 2'd0, 1'b0, 1'b0, 2'b00);
    pulse_ack();
    drain();

    // Hits on frames 1 and 3 only; crash_ack while armed has no effect
    pulse_start();
    frame_chk("t3_f1", 0, 1, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    expect_out("t3_ack_ignored", 0, 2'd2, 1'b0, 1'b0, 2'b00);
    pulse_ack();
    drain();
    frame_chk("t3_f2", 0, 0, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    frame_chk("t3_f3", 0, 1, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    do_reset();

    // Both bikes hit together -> draw
    pulse_start();
    frame_chk("t4_f1", 0, 1, 1, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    frame_chk("t4_f2", 0, 1, 1, 0, 2'd3, 1'b1, 1'b1, 2'b11);
    expect_out("t4_ack", 0, 2'd0, 1'b0, 1'b0, 2'b00);
    pulse_ack();
    drain();

    // Hit presented only on the frame_end cycle still counts
    pulse_start();
    frame_chk("t6_end_f1", 0, 0, 0, 1, 2'd2, 1'b0, 1'b0, 2'b00);
    frame_chk("t6_end_f2", 0, 1, 0, 0, 2'd3, 1'b1, 1'b0, 2'b01);
    pulse_ack();

    // Bike 0 near the bottom facing down: probe 310245 is off-screen and must never fire
    bike0_mid = 19'd300000; bike0_orient = 2'd2;
    target0   = 19'd310245;
    pulse_start();
    frame_chk("t6_oob_f1", 0, 1, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    frame_chk("t6_oob_f2", 0, 1, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    frame_chk("t6_oob_f3", 0, 1, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    do_reset();

    // Grace period of three frames, bike 0 hitting every frame from the start
    bike0_mid = 19'd100000; bike0_orient = 2'd0;
    target0   = 19'd89765;
    pulse_start();
    frame_chk("t5_f1", 1, 1, 0, 0, 2'd1, 1'b0, 1'b0, 2'b00);
    expect_out("t5_f2_a", 0, 2'd3, 1'b1, 1'b0, 2'b01);
    frame_chk("t5_f2", 1, 1, 0, 0, 2'd1, 1'b0, 1'b0, 2'b00);
    frame_chk("t5_f3", 1, 1, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    frame_chk("t5_f4", 1, 1, 0, 0, 2'd2, 1'b0, 1'b0, 2'b00);
    frame_chk("t5_f5", 1, 1, 0, 0, 2'd3, 1'b1, 1'b0, 2'b01);
    expect_out("t5_ack", 1, 2'd0, 1'b0, 1'b0, 2'b00);
    pulse_ack();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
